// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one SRAM macro (1 read port, 1 lane-masked write port, fixed read
//   latency) among NREQ requesters. The read and write ports each have their
//   own round-robin arbiter, so one read and one write can issue per cycle.
//   The requester ID of every issued read travels down a READ_LAT-deep tag
//   pipe so the returned sram_rdata is flagged for the requester that asked.
//
//   Optional feature macro: SRAM_ARB_RAW_STALL_EN
//     defined   : a read whose address matches the write granted in the same
//                 cycle is held back one cycle, so it returns post-write data.
//     undefined : no address compare; such a read returns pre-write data.
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter  int NREQ     = 2,
  parameter  int WIDTH    = 512,
  parameter  int LOGDEPTH = 9,
  parameter  int WORDSIZE = 64,
  parameter  int READ_LAT = 1,
  localparam int NLANE    = WIDTH / WORDSIZE,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  // read requesters
  input  logic [NREQ-1:0]           rd_valid,
  output logic [NREQ-1:0]           rd_ready,
  input  logic [NREQ*LOGDEPTH-1:0]  rd_addr,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  // write requesters
  input  logic [NREQ-1:0]           wr_valid,
  output logic [NREQ-1:0]           wr_ready,
  input  logic [NREQ*LOGDEPTH-1:0]  wr_addr,
  input  logic [NREQ*WIDTH-1:0]     wr_data,
  input  logic [NREQ*NLANE-1:0]     wr_be,
  // SRAM macro
  output logic [LOGDEPTH-1:0]       sram_raddr,
  input  logic [WIDTH-1:0]          sram_rdata,
  output logic [LOGDEPTH-1:0]       sram_waddr,
  output logic [WIDTH-1:0]          sram_wdata,
  output logic [NLANE-1:0]          sram_we
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // First set bit of valid, searching upward from ptr and wrapping at NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] grant;
    int              idx;
    grant = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (grant == '0 && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

  // Index of the (single) set bit of a one-hot grant; 0 when empty.
  function automatic logic [IDW-1:0] onehot_to_id(input logic [NREQ-1:0] oh);
    logic [IDW-1:0] id;
    id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) id = IDW'(i);
    end
    return id;
  endfunction

  // Pointer that follows a grant to k: (k+1) mod NREQ.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]      r_rd_ptr;
  logic [IDW-1:0]      r_wr_ptr;
  logic [LOGDEPTH-1:0] r_raddr;
  logic                r_tag_vld [READ_LAT];
  logic [IDW-1:0]      r_tag_id  [READ_LAT];

  // ---------------------------------------------------------------------------
  // Arbitration wires
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]     w_rd_req;
  logic [NREQ-1:0]     w_rd_cand;
  logic [IDW-1:0]      w_rd_id;
  logic [LOGDEPTH-1:0] w_rd_addr;
  logic [NREQ-1:0]     w_rd_grant;
  logic                w_rd_any;

  logic [NREQ-1:0]     w_wr_req;
  logic [NREQ-1:0]     w_wr_grant;
  logic [IDW-1:0]      w_wr_id;
  logic                w_wr_any;
  logic [LOGDEPTH-1:0] w_wr_addr;

  // Requests are masked during reset so nothing is granted or written.
  assign w_rd_req  = reset ? '0 : rd_valid;
  assign w_wr_req  = reset ? '0 : wr_valid;

  // Write port: round-robin winner, posted straight to the SRAM.
  assign w_wr_grant = rr_pick(w_wr_req, r_wr_ptr);
  assign w_wr_id    = onehot_to_id(w_wr_grant);
  assign w_wr_any   = |w_wr_grant;
  assign w_wr_addr  = wr_addr[int'(w_wr_id)*LOGDEPTH +: LOGDEPTH];

  // Read port: round-robin candidate before any hazard filtering.
  assign w_rd_cand  = rr_pick(w_rd_req, r_rd_ptr);
  assign w_rd_id    = onehot_to_id(w_rd_cand);
  assign w_rd_addr  = rd_addr[int'(w_rd_id)*LOGDEPTH +: LOGDEPTH];

`ifdef SRAM_ARB_RAW_STALL_EN
  // A read colliding with this cycle's write waits a cycle so it sees the
  // new data; the write itself is never held back.
  logic w_raw_hit;
  assign w_raw_hit  = w_wr_any && (|w_rd_cand) && (w_rd_addr == w_wr_addr);
  assign w_rd_grant = w_raw_hit ? '0 : w_rd_cand;
`else
  // Same-address read and write both issue; the SRAM returns pre-write data.
  assign w_rd_grant = w_rd_cand;
`endif

  assign w_rd_any   = |w_rd_grant;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_ready   = w_rd_grant;
  assign wr_ready   = w_wr_grant;

  assign sram_waddr = w_wr_addr;
  assign sram_wdata = wr_data[int'(w_wr_id)*WIDTH +: WIDTH];
  assign sram_we    = w_wr_any ? wr_be[int'(w_wr_id)*NLANE +: NLANE] : '0;

  // Idle cycles replay the last issued address so the SRAM input is quiet.
  assign sram_raddr = w_rd_any ? w_rd_addr : r_raddr;

  assign rsp_data   = sram_rdata;

  // Decode the tag leaving the pipe into a one-hot response strobe.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and a latch is never built.
    rsp_valid = '0;
    if (r_tag_vld[READ_LAT-1]) rsp_valid[r_tag_id[READ_LAT-1]] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Round-robin pointers advance past the requester just granted.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement or block ordering.
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_rd_any) r_rd_ptr <= next_ptr(w_rd_id);
      if (w_wr_any) r_wr_ptr <= next_ptr(w_wr_id);
    end
  end

  // Remember the last issued read address for idle cycles.
  always_ff @(posedge clk) begin
    if (reset)         r_raddr <= '0;
    else if (w_rd_any) r_raddr <= w_rd_addr;
  end

  // Tag pipe valid bits: cleared by reset, which drops reads in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < READ_LAT; j++) r_tag_vld[j] <= 1'b0;
    end else begin
      r_tag_vld[0] <= w_rd_any;
      for (int j = 1; j < READ_LAT; j++) r_tag_vld[j] <= r_tag_vld[j-1];
    end
  end

  // Tag pipe IDs travel alongside their valid bits.
  always_ff @(posedge clk) begin
    // NOTE: the ID stages are not reset; they are only observed when the
    // matching valid bit is set, and valids are reset.
    r_tag_id[0] <= w_rd_id;
    for (int j = 1; j < READ_LAT; j++) r_tag_id[j] <= r_tag_id[j-1];
  end

endmodule
